// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: channel modes
// and the standard divisors for a 100 MHz system clock.
package clk_div_pkg;

   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } mode_e;

   localparam int unsigned CLK_HZ   = 100_000_000;
   localparam int unsigned DIV_1HZ  = 100_000_000;
   localparam int unsigned DIV_2HZ  = 50_000_000;
   localparam int unsigned DIV_1KHZ = 100_000;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: programmable divisor, periodic or one-shot mode,
// registered one-cycle tick, toggling square wave and one-shot done flag.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W    = 27,
   parameter int unsigned DEF_DIV  = DIV_1HZ,
   parameter int unsigned DEF_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             wr,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_mode,
   output logic             tick,
   output logic             sq,
   output logic             done
);

   localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
   localparam mode_e            RST_MODE = (DEF_MODE != 0) ? MODE_ONESHOT : MODE_PERIODIC;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div;
   mode_e            mode;
   logic             active;
   logic             wrap;

   // Channel counts only when enabled, not disabled by div==0, and not a finished one-shot;
   // the div-1 compare is only consulted when div is non-zero.
   always_comb begin
      active = en && (div != '0) && !((mode == MODE_ONESHOT) && done);
      wrap   = (cnt == (div - CNT_W'(1)));
   end

   // Configuration, counter and registered outputs; clr/write override counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         div  <= RST_DIV;
         mode <= RST_MODE;
         tick <= 1'b0;
         sq   <= 1'b0;
         done <= 1'b0;
      end else if (clr || wr) begin
         if (wr) begin
            div  <= div_val;
            mode <= mode_e'(div_mode);
         end
         cnt  <= '0;
         tick <= 1'b0;
         done <= 1'b0;
         if (clr) begin
            sq <= 1'b0;
         end
      end else if (active) begin
         if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
            sq   <= ~sq;
            if (mode == MODE_ONESHOT) begin
               done <= 1'b1;
            end
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/multi_clk_divider.sv
// Multi-channel clock-enable divider: NUM_CH independent channels sharing
// enable and clear, with an indexed configuration write port.
module multi_clk_divider
   import clk_div_pkg::*;
#(
   parameter  int unsigned NUM_CH   = 4,
   parameter  int unsigned CNT_W    = 27,
   parameter  int unsigned DEF_DIV  = DIV_1HZ,
   parameter  int unsigned DEF_MODE = 0,
   localparam int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              div_wr,
   input  logic [SEL_W-1:0]  div_sel,
   input  logic [CNT_W-1:0]  div_val,
   input  logic              div_mode,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq,
   output logic [NUM_CH-1:0] done
);

   if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
      $error("multi_clk_divider: NUM_CH must be in 1..16");
   end
   if (64'(DEF_DIV) >= (64'd1 << CNT_W)) begin : g_bad_def_div
      $error("multi_clk_divider: DEF_DIV does not fit in CNT_W bits");
   end
   if (DEF_MODE > 1) begin : g_bad_def_mode
      $error("multi_clk_divider: DEF_MODE must be 0 or 1");
   end

   logic [NUM_CH-1:0] wr;

   // Decode the write index; indices at or above NUM_CH select nothing.
   always_comb begin
      wr = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         wr[i] = div_wr && (32'(div_sel) == i);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_channel #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV),
         .DEF_MODE(DEF_MODE)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .clr     (clr),
         .wr      (wr[i]),
         .div_val (div_val),
         .div_mode(div_mode),
         .tick    (tick[i]),
         .sq      (sq[i]),
         .done    (done[i])
      );
   end

endmodule

// File: doc/multi_clk_divider.md
Name: multi_clk_divider

Overview:
- Parametrised, multi-channel successor to the single fixed 1 s divider.
- Each channel has its own runtime-programmable divisor and a periodic or one-shot mode.
- Each channel outputs a one-cycle tick enable and a toggling square wave.
- Consumers: timekeeping (1 Hz), colon/alarm blink (2 Hz), display refresh (kHz), buzzer tone; all stay in the clk domain and use tick as a clock enable.

Parameters:
- NUM_CH, 4: number of independent divider channels (1..16).
- CNT_W, 27: width of the divisor and counter registers.
- DEF_DIV, 100_000_000: divisor loaded into every channel at reset. Must be < 2**CNT_W; elaboration error otherwise.
- DEF_MODE, 0: mode loaded at reset (0 = periodic, 1 = one-shot).

Ports:
- clk  in  1  system clock, 100 MHz nominal
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global count enable; low freezes all channels
- clr  in  1  synchronous restart of all channels (counters, sq, one-shot re-arm)
- div_wr  in  1  write strobe for channel configuration
- div_sel  in  $clog2(NUM_CH) (min 1)  channel index for the write
- div_val  in  CNT_W  new divisor
- div_mode  in  1  new mode (0 periodic, 1 one-shot)
- tick  out  NUM_CH  one-cycle pulse per channel
- sq  out  NUM_CH  square wave per channel, toggles on each tick
- done  out  NUM_CH  one-shot finished flag per channel

Behaviour:
- Reset is asynchronous: rst is the clock is clk, asynchronous, active-high. It sets cnt=0, div=DEF_DIV, mode=DEF_MODE, tick=0, sq=0, done=0 for every channel.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Counting: on each rising edge with en=1, an active channel with div>=1 increments cnt.
  - When cnt==div-1, cnt wraps to 0 and tick is registered high for exactly one cycle.
  - Result: tick pulses every div enabled edges. The first pulse follows the div-th enabled edge after reset, clr or a write.
- sq inverts on every edge that raises tick, so the sq period is 2*div enabled cycles with a 50% duty cycle.
- div==1: tick is high on every enabled cycle, and sq toggles every cycle.
- div==0: the channel is disabled. cnt is held at 0, tick=0, and sq and done hold their values.
- en=0: cnt, sq and done hold; tick=0. The count resumes where it stopped; no cycles are lost or added.
- One-shot mode (mode=1):
  - On its first tick the channel sets done=1, sq toggles once, and the counter stops at 0.
  - No further ticks occur until a write to that channel or clr; either one clears done and re-arms the channel.
- Write (div_wr=1):
  - The selected channel loads div=div_val and mode=div_mode, and sets cnt=0 and done=0.
  - tick is forced to 0 in the write cycle; sq is unchanged.
  - Other channels are unaffected.
  - div_sel>=NUM_CH: the write is ignored.
- clr=1: every channel sets cnt=0, tick=0, sq=0 and done=0, keeping its div and mode.
  - clr acts regardless of en.
  - clr and div_wr in the same cycle: both take effect (new config loaded, all counters cleared).
- Priority per channel: rst > clr/write > en-gated counting.
- Arithmetic: cnt is CNT_W bits and compares against div-1 computed in CNT_W bits. The div==0 case is guarded before the subtraction, so there is no wrap.
- rst asserted mid-count immediately returns all state to reset values; no partial tick is emitted.

Decomposition:
- Package clk_div_pkg holds:
  - the mode constants MODE_PERIODIC=1'b0 and MODE_ONESHOT=1'b1;
  - CLK_HZ=100_000_000;
  - divisor constants DIV_1HZ=100_000_000, DIV_2HZ=50_000_000, DIV_1KHZ=100_000.
- Sub-module clk_div_channel holds one channel: cnt, div, mode, tick, sq, done. It takes clk, rst, en, clr, a per-channel wr, div_val and div_mode. The top instantiates NUM_CH copies in a generate loop and decodes div_sel into the per-channel wr strobes.

Test Plan:
- Reset with DEF_DIV=4, NUM_CH=2, en=1 -> all outputs 0 during reset; tick[0] and tick[1] high on cycles 4, 8, 12 after release; sq high from cycle 4, low from cycle 8.
- Write ch1 div=3 periodic mid-count, ch0 untouched -> ch1 ticks 3, 6, 9 cycles after the write cycle, with no tick in the write cycle; ch0 cadence unchanged.
- Write ch0 div=5 one-shot -> single tick 5 cycles after the write, done[0]=1 and held; no further tick over 20 cycles; clr -> done[0]=0, next tick 5 cycles later.
- en deasserted for 7 cycles at cnt==2 with div=4 -> no ticks while low; next tick exactly 2 enabled cycles after en returns high.
- div=1 and div=0 writes -> div=1: tick every enabled cycle, sq toggles each cycle; div=0: tick stays 0 for 50 cycles and sq holds.
- Edge collisions: div_sel=NUM_CH write is ignored; clr+div_wr in the same cycle loads the new div and clears all counters; rst pulsed mid-count (async, between edges) clears tick, sq and done immediately.
